shuffle_unit: RTL and testbench
===============================

SHUFFLE_UNIT -- requirements
Module: shuffle_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of any operation in progress.
REQ-005 SHALL have port in_valid  input  1  operand offered.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operand.
REQ-007 SHALL have port data  input  32  source operand.
REQ-008 SHALL have port ctrl  input  4  stage-enable control {s8,s4,s2,s1}, i.e. rs2[3:0].
REQ-009 SHALL have port op_unshfl  input  1  0 = shfl (encode), 1 = unshfl (decode).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  32  shuffled/unshuffled value.

Function
REQ-013 SHALL define stage N (N = 8,4,2,1) as: x = (src & ~(L|R)) | ((src << N) & L) | ((src >> N) & R), with masks (L,R) = (0x00FF0000,0x0000FF00), (0x0F000F00,0x00F000F0), (0x30303030,0x0C0C0C0C), (0x44444444,0x22222222).
REQ-014 SHALL apply enabled stages in order 8,4,2,1 for shfl and 1,2,4,8 for unshfl, so that unshfl(shfl(x,c),c) = x for all x and c.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 SHALL, on a clock edge with in_valid && in_ready, latch data, ctrl and op_unshfl, clear the 2-bit stage counter and enter BUSY.
REQ-017 SHALL, in BUSY, process exactly one stage slot per cycle; a disabled stage passes the value unchanged.
REQ-018 SHALL use a fixed latency independent of ctrl: out_valid rises on the 4th rising edge after the accepting edge.
REQ-019 SHALL, on the 4th BUSY edge, when the counter wraps 3 -> 0, enter DONE.
REQ-020 SHALL hold result and out_valid stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-021 SHALL NOT accept a new operand on the edge that retires a result, because in_ready is low in DONE; this gives a minimum initiation interval of 6 cycles.
REQ-022 SHALL ignore in_valid, data, ctrl and op_unshfl outside IDLE.
REQ-023 SHALL, when flush is high, go to IDLE on the next edge from any state, discarding the operand; flush takes priority over acceptance and retirement in the same cycle.
REQ-024 SHALL drive result equal to the working register at all times; its value is only meaningful while out_valid is high.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force state = IDLE, counter = 0, working register = 0, so that in_ready = 1, out_valid = 0 and result = 0.
REQ-026 SHALL abandon an in-flight operation when reset is applied mid-BUSY or mid-DONE, with no output produced after release.
REQ-027 SHALL resume operation on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL place the four (L,R) mask constants, the shift amounts, and the FSM state enum in the shared package bitmanip_pkg.
REQ-029 SHALL instantiate a single combinational sub-module shfl_stage (inputs src, stage index, enable; output dst), time-multiplexed by the counter and direction.
REQ-030 SHALL map counter k to stage index k for shfl (8,4,2,1) and to 3-k for unshfl.

Verification
REQ-031 SHALL cover: shfl, data=0x12345678, ctrl=0x8 -> result 0x12563478, out_valid on the 4th edge after acceptance.
REQ-032 SHALL cover: shfl, data=0x0000FFFF, ctrl=0xF -> 0x55555555; then unshfl of 0x55555555 with ctrl=0xF -> 0x0000FFFF.
REQ-033 SHALL cover: ctrl=0x0 in either direction, data=0xDEADBEEF -> 0xDEADBEEF with the same 4-cycle latency.
REQ-034 SHALL cover: out_ready held low 10 cycles in DONE -> result and out_valid stable, in_ready low, a new in_valid ignored.
REQ-035 SHALL cover: flush in BUSY cycle 2, and separately rst_n pulsed low in BUSY -> IDLE, in_ready=1, out_valid never asserts for that operand.
REQ-036 SHALL cover: 1000 random (data, ctrl) pairs run shfl then unshfl -> round-trip equals the original data; checks against a reference model.

Source files
------------

// File: rtl/bitmanip_pkg.sv
// Shared constants for the bit-manipulation shuffle datapath: the stage masks,
// the shift amounts and the shuffle FSM state encoding.
// Stage slot k (0..3) is the N=8,4,2,1 stage respectively.
package bitmanip_pkg;

  localparam int STAGES = 4;

  // Packed arrays: element [0] is the N=8 stage, element [3] is the N=1 stage.
  localparam logic [3:0][31:0] STAGE_L = {
    32'h44444444, 32'h30303030, 32'h0F000F00, 32'h00FF0000
  };
  localparam logic [3:0][31:0] STAGE_R = {
    32'h22222222, 32'h0C0C0C0C, 32'h00F000F0, 32'h0000FF00
  };
  localparam logic [3:0][4:0] STAGE_SH = {5'd1, 5'd2, 5'd4, 5'd8};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shuffle_unit_if.sv
// Operand/result handshake bundle for shuffle_unit.
// Ports: in_valid/in_ready/data/ctrl/op_unshfl (operand side),
//        out_valid/out_ready/result (result side).
interface shuffle_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] data;
  logic [3:0]      ctrl;
  logic            op_unshfl;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  // master: the producer/consumer around the unit; slave: the unit itself
  modport master (
    output in_valid, data, ctrl, op_unshfl, out_ready,
    input  in_ready, out_valid, result
  );
  modport slave (
    input  in_valid, data, ctrl, op_unshfl, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/shfl_stage.sv
// One butterfly stage of the generalized shuffle: swaps the L and R bit groups
// of the selected stage, or passes src through when the stage is disabled.
// Ports: src (operand), idx (stage slot 0..3 = N 8,4,2,1), en, dst. Combinational.
module shfl_stage
  import bitmanip_pkg::*;
(
  input  logic [31:0] src,
  input  logic [1:0]  idx,
  input  logic        en,
  output logic [31:0] dst
);

  logic [31:0] mask_l;
  logic [31:0] mask_r;
  logic [4:0]  shamt;
  logic [31:0] swapped;

  always_comb begin
    mask_l  = STAGE_L[idx];
    mask_r  = STAGE_R[idx];
    shamt   = STAGE_SH[idx];
    // R = L >> N, so this exchanges the two groups; the stage is its own inverse.
    swapped = (src & ~(mask_l | mask_r))
            | ((src << shamt) & mask_l)
            | ((src >> shamt) & mask_r);
    dst     = en ? swapped : src;
  end

endmodule

// File: rtl/shuffle_unit.sv
// Iterative shfl/unshfl unit: one stage slot per cycle through a shared shfl_stage.
// Latency: result valid 4 edges after acceptance, independent of ctrl; II >= 6 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts.
// Ports: clk, rst_n (async active-low), flush (sync abort), bus (operand/result handshake).
module shuffle_unit
  import bitmanip_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  shuffle_unit_if.slave  bus
);

  state_t          state, state_nxt;
  logic [1:0]      cnt, cnt_nxt;
  logic [XLEN-1:0] work, work_nxt;
  logic [3:0]      ctrl_q, ctrl_nxt;
  logic            op_q, op_nxt;

  logic [1:0]      stage_idx;
  logic            stage_en;
  logic [31:0]     stage_out;

  // shfl walks N=8,4,2,1; unshfl walks the same stages backwards so it inverts shfl.
  assign stage_idx = op_q ? (2'd3 - cnt) : cnt;
  // ctrl is {s8,s4,s2,s1}: slot 0 (N=8) is bit 3.
  assign stage_en  = ctrl_q[2'd3 - stage_idx];

  shfl_stage u_stage (
    .src (work),
    .idx (stage_idx),
    .en  (stage_en),
    .dst (stage_out)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = work;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    ctrl_nxt  = ctrl_q;
    op_nxt    = op_q;

    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work_nxt  = bus.data;
            ctrl_nxt  = bus.ctrl;
            op_nxt    = bus.op_unshfl;
            cnt_nxt   = 2'd0;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          work_nxt = stage_out;
          cnt_nxt  = cnt + 2'd1;
          if (cnt == 2'd3) state_nxt = DONE;
        end
        DONE: begin
          if (bus.out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      work   <= '0;
      ctrl_q <= 4'd0;
      op_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      work   <= work_nxt;
      ctrl_q <= ctrl_nxt;
      op_q   <= op_nxt;
    end
  end

endmodule

// File: tb/tb_shuffle_unit.sv
// Self-checking bench for shuffle_unit: directed vector table, stall/flush/reset
// sequences, and a random shfl->unshfl round trip against a reference model.
module tb_shuffle_unit;

  logic clk;
  logic rst_n;
  logic flush;

  shuffle_unit_if #(.XLEN(32)) bus ();

  shuffle_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: straight from the stage formula with its own mask table.
  function automatic logic [31:0] stage_ref(input logic [31:0] s, input int n);
    logic [31:0] l;
    logic [31:0] r;
    case (n)
      8: begin l = 32'h00FF0000; r = 32'h0000FF00; end
      4: begin l = 32'h0F000F00; r = 32'h00F000F0; end
      2: begin l = 32'h30303030; r = 32'h0C0C0C0C; end
      default: begin l = 32'h44444444; r = 32'h22222222; end
    endcase
    return (s & ~(l | r)) | ((s << n) & l) | ((s >> n) & r);
  endfunction

  function automatic logic [31:0] shuffle_ref(input logic op, input logic [31:0] d,
                                               input logic [3:0] c);
    logic [31:0] x;
    int          order [4];
    x = d;
    if (!op) order = '{8, 4, 2, 1};
    else     order = '{1, 2, 4, 8};
    for (int i = 0; i < 4; i++) begin
      // bit 3 enables N=8, bit 0 enables N=1
      if ((order[i] == 8 && c[3]) || (order[i] == 4 && c[2]) ||
          (order[i] == 2 && c[1]) || (order[i] == 1 && c[0]))
        x = stage_ref(x, order[i]);
    end
    return x;
  endfunction

  task automatic start_op(input logic op, input logic [31:0] d, input logic [3:0] c);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.data      = d;
    bus.ctrl      = c;
    bus.op_unshfl = op;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; counts edges until out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic op, input logic [31:0] d, input logic [3:0] c,
                        output logic [31:0] res, output int lat);
    start_op(op, d, c);
    wait_done(lat);
    res = bus.result;
    retire();
  endtask

  // Count out_valid cycles over a window; used to prove an operand was dropped.
  task automatic watch_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
  endtask

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] data;
    logic [3:0]  ctrl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] res;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] d;
    logic [3:0]  c;
    int          lat;
    int          seen;
    int          bad;

    vecs[0] = '{"shfl_c8",      1'b0, 32'h12345678, 4'h8, 32'h12563478};
    vecs[1] = '{"shfl_cF",      1'b0, 32'h0000FFFF, 4'hF, 32'h55555555};
    vecs[2] = '{"unshfl_cF",    1'b1, 32'h55555555, 4'hF, 32'h0000FFFF};
    vecs[3] = '{"shfl_c0",      1'b0, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF};
    vecs[4] = '{"unshfl_c0",    1'b1, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF};
    vecs[5] = '{"shfl_c1",      1'b0, 32'h12345678, 4'h1, 32'h14523678};
    vecs[6] = '{"shfl_c4",      1'b0, 32'h12345678, 4'h4, 32'h13245768};
    vecs[7] = '{"unshfl_c8",    1'b1, 32'h12563478, 4'h8, 32'h12345678};

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data      = '0;
    bus.ctrl      = '0;
    bus.op_unshfl = 1'b0;
    bus.out_ready = 1'b0;

    #1;
    chk("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_result",    bus.result,             32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: value and fixed 4-edge latency
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].data, vecs[i].ctrl, res, lat);
      chk({vecs[i].name, "_result"}, res, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, lat, 32'd4);
      chk({vecs[i].name, "_idle_after"}, {31'd0, bus.in_ready}, 32'd1);
    end

    // Stall in DONE for 10 cycles with a competing operand offered
    start_op(1'b0, 32'h12345678, 4'h8);
    wait_done(lat);
    chk("stall_latency", lat, 32'd4);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.data      = 32'hFFFFFFFF;
      bus.ctrl      = 4'hF;
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'h12563478)
        bad++;
    end
    chk("stall_stable_cycles_bad", bad, 32'd0);
    bus.in_valid = 1'b0;
    retire();
    chk("stall_retire_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("stall_retire_out_valid", {31'd0, bus.out_valid}, 32'd0);
    watch_valid(8, seen);
    chk("stall_no_phantom_op", seen, 32'd0);

    // Flush during the second BUSY cycle
    start_op(1'b0, 32'hCAFEF00D, 4'hF);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    watch_valid(8, seen);
    chk("flush_no_output", seen, 32'd0);

    // Flush wins over acceptance in the same cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data     = 32'h0000FFFF;
    bus.ctrl     = 4'hF;
    flush        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    chk("flush_prio_in_ready", {31'd0, bus.in_ready}, 32'd1);
    watch_valid(8, seen);
    chk("flush_prio_no_output", seen, 32'd0);

    // Reset pulse mid-BUSY
    start_op(1'b0, 32'h0000FFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_busy_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy_result",    bus.result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_valid(8, seen);
    chk("rst_busy_no_output", seen, 32'd0);

    // Reset pulse mid-DONE
    start_op(1'b0, 32'h12345678, 4'h8);
    wait_done(lat);
    chk("rst_done_reached", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_valid(8, seen);
    chk("rst_done_no_output", seen, 32'd0);

    // Operation resumes after reset
    run_op(1'b0, 32'h12345678, 4'h8, res, lat);
    chk("resume_result",  res, 32'h12563478);
    chk("resume_latency", lat, 32'd4);

    // Random round trips
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      c = 4'($urandom_range(0, 15));
      run_op(1'b0, d, c, r1, lat);
      chk($sformatf("rand%0d_shfl", i), r1, shuffle_ref(1'b0, d, c));
      run_op(1'b1, r1, c, r2, lat);
      chk($sformatf("rand%0d_roundtrip", i), r2, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
